inject_sequencer: RTL
=====================

Name: inject_sequencer

Overview:
- Single controller that replaces the separate call/ret/rti/interrupt micro-sequencers in the pipelined processor.
- Arbitrates among decode-stage CALL/RET/RTI requests and the external interrupt line.
- Drives the injected-instruction word into the fetch/decode path, the PC-hold stall, and the PC-override (value + select).
- Guarantees one sequence at a time, with deterministic priority and interrupt deferral.

Parameters:
IW, 16, instruction word width
PCW, 32, PC width
INT_VEC, 32'h0000_0000, PC loaded at end of interrupt sequence

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
hold  in  1  load-use stall; freezes sequencer
call_req  in  1  decode holds CALL
ret_req  in  1  decode holds RET
rti_req  in  1  decode holds RTI
rdst_value  in  16  CALL target (Rdst), valid with call_req
int_flag  in  1  external interrupt line, level
inject_instr  out  IW  word muxed into F/D when stall=1
stall  out  1  hold PC, select inject_instr
pc_change  out  1  load pc_value into PC this cycle
pc_value  out  PCW  override PC
ack  out  1  interrupt acknowledge pulse
busy  out  1  state != IDLE

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port named reset.
- Reset values:
  - All outputs 0; inject_instr = OP_NOP.
  - State IDLE, step 0, int_pending 0, int_prev 1 (an interrupt line held high through reset does not fire).
- Reset mid-sequence aborts to IDLE and clears int_pending.
- State machine: IDLE, CALL, RET, RTI, INT, plus a 2-bit step counter. Outputs are Moore, decoded from the state registers.
- Sequences (words from the package), with length in cycles:
  - CALL = PUSH_PC_HI, PUSH_PC_LO (2)
  - INT = PUSH_PC_HI, PUSH_PC_LO, PUSH_CCR (3)
  - RET = POP_PC_LO, POP_PC_HI, NOP (3)
  - RTI = POP_CCR, POP_PC_LO, POP_PC_HI, NOP (4)
- Start, in IDLE with hold=0 at edge t:
  - Priority order: rti_req > ret_req > call_req > int_pending.
  - The selected state is entered at t+1 with step 0.
  - A decode request always beats a same-cycle interrupt edge; the interrupt stays pending.
  - CALL latches rdst_value into the target register at edge t.
- While in a sequence:
  - stall=1 and inject_instr=SEQ[step].
  - Step increments each cycle when hold=0.
  - When hold=1, state, step and outputs are frozen.
- Last step:
  - CALL: pc_change=1, pc_value = {16'b0, target}.
  - INT: pc_change=1, pc_value = INT_VEC.
  - RET/RTI: pc_change stays 0; PC is restored via writeback.
  - Next state is INT if int_pending (and not reset), else IDLE. There is no IDLE gap before a pending interrupt.
- Interrupt detect:
  - Rising edge of int_flag (int_flag & ~int_prev) sets int_pending.
  - Edges during busy are latched, never preempting a running sequence.
  - Multiple edges before service collapse to one.
  - int_pending clears on entry to INT.
- ack is high for exactly one cycle: the first cycle of INT step 0. It is not repeated if hold extends step 0.
- call_req/ret_req/rti_req while busy are ignored.
- Outside sequences: stall=0, pc_change=0, inject_instr=OP_NOP, pc_value=0.

Decomposition:
- Shared package holds:
  - Opcode constants OP_NOP, OP_PUSH_PC_HI, OP_PUSH_PC_LO, OP_PUSH_CCR, OP_POP_PC_LO, OP_POP_PC_HI, OP_POP_CCR, matching the control-unit encodings.
  - The state enum.
  - Sequence-length constants CALL_LEN=2, RET_LEN=3, RTI_LEN=4, INT_LEN=3.
- One sub-module: int_edge_latch. It contains the int_prev register, the rising-edge detect and the int_pending set/clear, with port clr driven on INT entry.

Test Plan:
1. CALL: call_req=1, rdst_value=16'h0040 at edge 0.
   - Cycles 1-2: stall=1, inject_instr = PUSH_PC_HI then PUSH_PC_LO.
   - Cycle 2: pc_change=1, pc_value=32'h0000_0040.
   - Cycle 3: busy=0.
2. RTI: rti_req=1.
   - Cycles 1-4: inject_instr = POP_CCR, POP_PC_LO, POP_PC_HI, NOP.
   - pc_change never asserted; cycle 5 stall=0.
3. Simultaneous requests: ret_req=1 and int_flag rises at edge 0.
   - RET runs cycles 1-3.
   - INT step 0 at cycle 4 with ack=1 for that cycle only.
   - Cycle 6: pc_change=1, pc_value=INT_VEC.
4. hold: hold=1 during CALL step 0 for 3 cycles.
   - inject_instr stays PUSH_PC_HI and stall=1 throughout.
   - pc_change is delayed by 3 cycles; a call_req pulse while busy has no effect.
5. Reset mid-RTI at step 2, with int_flag held high through reset.
   - Next cycle: all outputs 0, busy=0.
   - No ack after reset until int_flag falls and rises again.
6. Edge collapse: two int_flag pulses during one RET.
   - Exactly one INT sequence and one ack follow.

Source files
------------

// File: rtl/inject_sequencer_pkg.sv
// inject_sequencer_pkg: opcodes, state enum, sequence lengths and word tables for the inject sequencer
package inject_sequencer_pkg;

    typedef enum logic [2:0] {S_IDLE, S_CALL, S_RET, S_RTI, S_INT} state_e;

    localparam logic [15:0] OP_NOP        = 16'h0000;
    localparam logic [15:0] OP_PUSH_PC_HI = 16'hE100;
    localparam logic [15:0] OP_PUSH_PC_LO = 16'hE200;
    localparam logic [15:0] OP_PUSH_CCR   = 16'hE300;
    localparam logic [15:0] OP_POP_PC_LO  = 16'hE400;
    localparam logic [15:0] OP_POP_PC_HI  = 16'hE500;
    localparam logic [15:0] OP_POP_CCR    = 16'hE600;

    localparam int CALL_LEN = 2;
    localparam int RET_LEN  = 3;
    localparam int RTI_LEN  = 4;
    localparam int INT_LEN  = 3;

    // Index of the final step of a sequence; IDLE reports 0.
    function automatic logic [1:0] seq_last(state_e s);
        return s == S_CALL ? 2'(CALL_LEN - 1) :
               s == S_RET  ? 2'(RET_LEN - 1)  :
               s == S_RTI  ? 2'(RTI_LEN - 1)  :
               s == S_INT  ? 2'(INT_LEN - 1)  : 2'd0;
    endfunction

    // Word injected at a given step of a sequence; NOP outside sequences.
    function automatic logic [15:0] seq_word(state_e s, logic [1:0] step);
        case (s)
            S_CALL:  return step == 2'd0 ? OP_PUSH_PC_HI : OP_PUSH_PC_LO;
            S_INT:   return step == 2'd0 ? OP_PUSH_PC_HI : step == 2'd1 ? OP_PUSH_PC_LO : OP_PUSH_CCR;
            S_RET:   return step == 2'd0 ? OP_POP_PC_LO : step == 2'd1 ? OP_POP_PC_HI : OP_NOP;
            S_RTI:   return step == 2'd0 ? OP_POP_CCR : step == 2'd1 ? OP_POP_PC_LO :
                            step == 2'd2 ? OP_POP_PC_HI : OP_NOP;
            default: return OP_NOP;
        endcase
    endfunction

endpackage

// File: rtl/inject_sequencer_if.sv
// inject_sequencer_if: decode/interrupt requests in, injection/PC-override controls out
//   hold, call_req, ret_req, rti_req, rdst_value, int_flag : requests toward the sequencer
//   inject_instr, stall, pc_change, pc_value, ack, busy     : controls from the sequencer
interface inject_sequencer_if #(
    parameter int IW  = 16,
    parameter int PCW = 32
);
    logic           hold;
    logic           call_req;
    logic           ret_req;
    logic           rti_req;
    logic [15:0]    rdst_value;
    logic           int_flag;
    logic [IW-1:0]  inject_instr;
    logic           stall;
    logic           pc_change;
    logic [PCW-1:0] pc_value;
    logic           ack;
    logic           busy;

    modport master (
        output hold, call_req, ret_req, rti_req, rdst_value, int_flag,
        input  inject_instr, stall, pc_change, pc_value, ack, busy
    );

    modport slave (
        input  hold, call_req, ret_req, rti_req, rdst_value, int_flag,
        output inject_instr, stall, pc_change, pc_value, ack, busy
    );
endinterface

// File: rtl/inject_sequencer_int_edge_latch.sv
// int_edge_latch: rising-edge detector on the interrupt line with a sticky pending flag
//   clk, reset     : clock, synchronous active-high reset
//   int_flag_i     : external interrupt level
//   clr_i          : pulse on entry to the interrupt sequence
//   int_pending_o  : an unserviced rising edge has been seen
module int_edge_latch (
    input  logic clk,
    input  logic reset,
    input  logic int_flag_i,
    input  logic clr_i,
    output logic int_pending_o
);
    logic int_prev_q;
    logic int_pending_q;
    logic int_pending_d;

    // A fresh edge in the same cycle as the clear is a new interrupt, so set wins.
    assign int_pending_d = (int_pending_q & ~clr_i) | (int_flag_i & ~int_prev_q);
    assign int_pending_o = int_pending_q;

    // int_prev resets high so a line held high through reset does not fire.
    always_ff @(posedge clk) begin
        if (reset) begin
            int_prev_q    <= 1'b1;
            int_pending_q <= 1'b0;
        end else begin
            int_prev_q    <= int_flag_i;
            int_pending_q <= int_pending_d;
        end
    end
endmodule

// File: rtl/inject_sequencer.sv
// inject_sequencer: arbitrates CALL/RET/RTI/interrupt and injects their micro-sequences into fetch/decode
//   clk, reset : clock, synchronous active-high reset
//   bus        : slave side of inject_sequencer_if (requests in, inject/stall/PC override/ack/busy out)
module inject_sequencer
    import inject_sequencer_pkg::*;
#(
    parameter int             IW      = 16,
    parameter int             PCW     = 32,
    parameter logic [PCW-1:0] INT_VEC = '0
) (
    input logic               clk,
    input logic               reset,
    inject_sequencer_if.slave bus
);
    state_e      state_q, state_d;
    logic [1:0]  step_q, step_d;
    logic        first_q, first_d;
    logic [15:0] target_q, target_d;
    logic        int_pending;
    logic        last_step;
    logic        enter_int;

    int_edge_latch u_int (
        .clk          (clk),
        .reset        (reset),
        .int_flag_i   (bus.int_flag),
        .clr_i        (enter_int),
        .int_pending_o(int_pending)
    );

    assign last_step = step_q == seq_last(state_q);
    // first_d marks the cycle a sequence is entered; it drives the single-cycle ack.
    assign enter_int = first_d && state_d == S_INT;

    always_comb begin
        state_d  = state_q;
        step_d   = step_q;
        target_d = target_q;
        first_d  = 1'b0;
        if (!bus.hold) begin
            if (state_q == S_IDLE) begin
                state_d  = bus.rti_req ? S_RTI : bus.ret_req ? S_RET :
                           bus.call_req ? S_CALL : int_pending ? S_INT : S_IDLE;
                step_d   = 2'd0;
                first_d  = state_d != S_IDLE;
                target_d = state_d == S_CALL ? bus.rdst_value : target_q;
            end else if (last_step) begin
                state_d = int_pending ? S_INT : S_IDLE;
                step_d  = 2'd0;
                first_d = int_pending;
            end else begin
                step_d = step_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            step_q   <= 2'd0;
            first_q  <= 1'b0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            first_q  <= first_d;
            target_q <= target_d;
        end
    end

    assign bus.busy         = state_q != S_IDLE;
    assign bus.stall        = bus.busy;
    assign bus.inject_instr = IW'(seq_word(state_q, step_q));
    assign bus.pc_change    = last_step && (state_q == S_CALL || state_q == S_INT);
    assign bus.pc_value     = !bus.pc_change ? '0 : state_q == S_CALL ? PCW'(target_q) : INT_VEC;
    assign bus.ack          = state_q == S_INT && step_q == 2'd0 && first_q;
endmodule
